// File: rtl/dl_rom_sequencer_if.sv
// Bundles the hps_io ioctl download stream (in) with the game-core ROM write / reset side (out).
// master = download source / bench, slave = dl_rom_sequencer.
interface dl_rom_sequencer_if #(
    parameter int unsigned ADDR_W = 17
) ();
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [3:0]        rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              game_reset;
    logic              dl_err;
    logic [15:0]       dl_sum;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  rom_we, rom_addr, rom_data, game_reset, dl_err, dl_sum
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output rom_we, rom_addr, rom_data, game_reset, dl_err, dl_sum
    );
endinterface

// File: rtl/dl_rom_sequencer.sv
// ROM download sequencer: region decode to one-hot strobes, 1-cycle write latency, no stall (a byte every cycle).
// Holds game_reset until a clean full image plus HOLD_CYCLES; optional byte checksum under DL_CHECKSUM_EN.
module dl_rom_sequencer #(
    parameter int unsigned       ADDR_W      = 17,
    parameter logic [ADDR_W-1:0] REG1_BASE   = 17'h04000,
    parameter logic [ADDR_W-1:0] REG2_BASE   = 17'h05000,
    parameter logic [ADDR_W-1:0] REG3_BASE   = 17'h06000,
    parameter logic [ADDR_W-1:0] IMG_TOP     = 17'h0A000,
    parameter int unsigned       HOLD_CYCLES = 64
) (
    input logic               clk_sys,
    input logic               reset,
    dl_rom_sequencer_if.slave bus
);

    localparam logic [16:0] CNT_TOP = 17'(IMG_TOP);
    localparam logic [15:0] HOLD_LD = 16'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_dl_prev;
    logic [3:0]        r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;
    logic              r_game_reset;
    logic              r_err;
    logic [16:0]       r_cnt;
    logic [ADDR_W-1:0] r_exp_addr;
    logic [15:0]       r_hold;

    logic              w_dl_rise;
    logic              w_dl_fall;
    logic              w_wr;
    logic              w_in_range;
    logic [3:0]        w_we_1h;
    logic [ADDR_W-1:0] w_base;
    logic              w_err_nxt;
    logic [16:0]       w_cnt_nxt;
    logic              w_complete;
    logic              w_load_entry;
    logic              w_hold_entry;
    logic              w_load_fail;

    assign w_dl_rise  = bus.ioctl_download & ~r_dl_prev;
    assign w_dl_fall  = ~bus.ioctl_download & r_dl_prev;
    assign w_wr       = bus.ioctl_wr && (r_state == S_LOAD);
    assign w_in_range = bus.ioctl_addr < IMG_TOP;

    always_comb begin
        w_we_1h = 4'b0000;
        w_base  = '0;
        if (bus.ioctl_addr < REG1_BASE) begin
            w_we_1h = 4'b0001;
        end else if (bus.ioctl_addr < REG2_BASE) begin
            w_we_1h = 4'b0010;
            w_base  = REG1_BASE;
        end else if (bus.ioctl_addr < REG3_BASE) begin
            w_we_1h = 4'b0100;
            w_base  = REG2_BASE;
        end else if (w_in_range) begin
            w_we_1h = 4'b1000;
            w_base  = REG3_BASE;
        end
    end

    // A byte arriving on the same edge as the download falling still counts toward completeness.
    assign w_err_nxt  = r_err | (w_wr && (!w_in_range || (bus.ioctl_addr != r_exp_addr)));
    assign w_cnt_nxt  = (w_wr && w_in_range && (r_cnt != '1)) ? r_cnt + 17'd1 : r_cnt;
    assign w_complete = (w_cnt_nxt == CNT_TOP) && !w_err_nxt;

    always_comb begin
        w_state_nxt  = r_state;
        w_load_entry = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_dl_rise) begin
                    w_state_nxt  = S_LOAD;
                    w_load_entry = 1'b1;
                end
            end
            S_LOAD: begin
                if (w_dl_fall) w_state_nxt = w_complete ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (w_dl_rise) begin
                    w_state_nxt  = S_LOAD;
                    w_load_entry = 1'b1;
                end else if (r_hold == 16'd0) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_dl_rise) begin
                    w_state_nxt  = S_LOAD;
                    w_load_entry = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_hold_entry = (r_state == S_LOAD) && (w_state_nxt == S_HOLD);
    assign w_load_fail  = (r_state == S_LOAD) && w_dl_fall && !w_complete;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_dl_prev <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dl_prev <= bus.ioctl_download;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_we         <= 4'b0000;
            r_addr       <= '0;
            r_data       <= 8'h00;
            r_game_reset <= 1'b1;
            r_err        <= 1'b0;
            r_cnt        <= '0;
            r_exp_addr   <= '0;
            r_hold       <= '0;
        end else begin
            r_game_reset <= (w_state_nxt != S_RUN);
            r_we         <= w_wr ? w_we_1h : 4'b0000;
            if (w_wr && w_in_range) begin
                r_addr <= bus.ioctl_addr - w_base;
                r_data <= bus.ioctl_dout;
            end

            if (w_load_entry) begin
                r_err      <= 1'b0;
                r_cnt      <= '0;
                r_exp_addr <= '0;
            end else if (r_state == S_LOAD) begin
                if (w_wr) r_exp_addr <= bus.ioctl_addr + 1'b1;
                r_cnt <= w_cnt_nxt;
                r_err <= w_load_fail ? 1'b1 : w_err_nxt;
            end

            if (w_hold_entry) begin
                r_hold <= HOLD_LD;
            end else if ((r_state == S_HOLD) && (r_hold != 16'd0)) begin
                r_hold <= r_hold - 16'd1;
            end
        end
    end

`ifdef DL_CHECKSUM_EN
    logic [15:0] r_sum;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_sum <= 16'h0000;
        end else if (w_load_entry) begin
            r_sum <= 16'h0000;
        end else if (w_wr && w_in_range) begin
            r_sum <= r_sum + {8'h00, bus.ioctl_dout};
        end
    end

    assign bus.dl_sum = r_sum;
`else
    assign bus.dl_sum = 16'h0000;
`endif

    assign bus.rom_we     = r_we;
    assign bus.rom_addr   = r_addr;
    assign bus.rom_data   = r_data;
    assign bus.game_reset = r_game_reset;
    assign bus.dl_err     = r_err;

endmodule
